// File: rtl/interlaken_msg_trigger_seq_if.sv
// Request/measurement bundle between the message trigger sequencer and its environment.
// INTERLAKEN_LAT_STATS_EN adds the latency statistics outputs.
interface interlaken_msg_trigger_seq_if #(
    parameter int NUM_MSG = 9,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               continuous;
    logic [NUM_MSG-1:0] msg_mask;
    logic [CNT_W-1:0]   gap_cycles;
    logic               rx_done;
    logic [NUM_MSG-1:0] send_msg;
    logic               busy;
    logic               lat_valid;
    logic [CNT_W-1:0]   lat_value;
    logic [3:0]         lat_msg;
    logic               lat_timeout;
    logic               pass_done;
`ifdef INTERLAKEN_LAT_STATS_EN
    logic [CNT_W-1:0]   lat_min;
    logic [CNT_W-1:0]   lat_max;
    logic [31:0]        lat_cnt;
    logic [15:0]        lost_cnt;

    modport master (
        output start, continuous, msg_mask, gap_cycles, rx_done,
        input  send_msg, busy, lat_valid, lat_value, lat_msg, lat_timeout, pass_done,
        input  lat_min, lat_max, lat_cnt, lost_cnt
    );
    modport slave (
        input  start, continuous, msg_mask, gap_cycles, rx_done,
        output send_msg, busy, lat_valid, lat_value, lat_msg, lat_timeout, pass_done,
        output lat_min, lat_max, lat_cnt, lost_cnt
    );
`else
    modport master (
        output start, continuous, msg_mask, gap_cycles, rx_done,
        input  send_msg, busy, lat_valid, lat_value, lat_msg, lat_timeout, pass_done
    );
    modport slave (
        input  start, continuous, msg_mask, gap_cycles, rx_done,
        output send_msg, busy, lat_valid, lat_value, lat_msg, lat_timeout, pass_done
    );
`endif
endinterface

// File: rtl/interlaken_msg_trigger_seq.sv
// Round-robin send_msg strobe generator that measures strobe-to-rx_done latency per message.
// Optional macro INTERLAKEN_LAT_STATS_EN adds min/max/count latency statistics.
module interlaken_msg_trigger_seq #(
    parameter int               NUM_MSG = 9,
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
    input logic                         init_clk,
    input logic                         clk_reset_n,
    interlaken_msg_trigger_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, FIRE = 2'd2, WAIT_DONE = 2'd3} state_t;

    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [NUM_MSG-1:0] MSG_ZERO = {NUM_MSG{1'b0}};
    localparam logic [NUM_MSG-1:0] MSG_ONE  = {{(NUM_MSG-1){1'b0}}, 1'b1};

    state_t             state_r, state_nxt_s;
    logic               start_prev_r, start_rise_s;
    logic [NUM_MSG-1:0] mask_r, mask_nxt_s;
    logic [CNT_W-1:0]   gap_r, gap_nxt_s;
    logic [3:0]         ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0]   gap_cnt_r, gap_cnt_nxt_s;
    logic [CNT_W-1:0]   lat_cnt_r, lat_cnt_nxt_s;
    logic [4:0]         adv_s;
    logic               launch_s, done_s;
    logic [NUM_MSG-1:0] send_msg_r, send_msg_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               lat_valid_r, lat_valid_nxt_s;
    logic [CNT_W-1:0]   lat_value_r, lat_value_nxt_s;
    logic [3:0]         lat_msg_r, lat_msg_nxt_s;
    logic               lat_timeout_r, lat_timeout_nxt_s;
    logic               pass_done_r, pass_done_nxt_s;
`ifdef INTERLAKEN_LAT_STATS_EN
    logic [CNT_W-1:0]   lat_min_r, lat_min_nxt_s;
    logic [CNT_W-1:0]   lat_max_r, lat_max_nxt_s;
    logic [31:0]        lat_cnt_stat_r, lat_cnt_stat_nxt_s;
    logic [15:0]        lost_cnt_r, lost_cnt_nxt_s;
`endif

    function automatic logic [3:0] lowest_f(input logic [NUM_MSG-1:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_MSG - 1; i >= 0; i--) begin
            r = m[i] ? 4'(i) : r;
        end
        return r;
    endfunction

    // Returns {wrap, next_ptr}: next set bit above p, or the lowest set bit with wrap=1.
    function automatic logic [4:0] advance_f(input logic [NUM_MSG-1:0] m, input logic [3:0] p);
        logic [3:0] r;
        logic       found;
        logic       hit;
        r     = lowest_f(m);
        found = 1'b0;
        for (int i = NUM_MSG - 1; i >= 0; i--) begin
            hit   = m[i] && (i > int'(p));
            r     = hit ? 4'(i) : r;
            found = found | hit;
        end
        return {~found, r};
    endfunction

    assign start_rise_s = bus.start & ~start_prev_r;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_nxt_s       = state_r;
        mask_nxt_s        = mask_r;
        gap_nxt_s         = gap_r;
        ptr_nxt_s         = ptr_r;
        gap_cnt_nxt_s     = gap_cnt_r;
        lat_cnt_nxt_s     = lat_cnt_r;
        send_msg_nxt_s    = MSG_ZERO;
        lat_valid_nxt_s   = 1'b0;
        lat_value_nxt_s   = lat_value_r;
        lat_msg_nxt_s     = lat_msg_r;
        lat_timeout_nxt_s = lat_timeout_r;
        pass_done_nxt_s   = 1'b0;
        launch_s          = 1'b0;
        done_s            = 1'b0;
        adv_s             = advance_f(mask_r, ptr_r);
        case (state_r)
            IDLE: begin
                if (start_rise_s && (bus.msg_mask != MSG_ZERO)) begin
                    state_nxt_s = GAP;
                    mask_nxt_s  = bus.msg_mask;
                    gap_nxt_s   = bus.gap_cycles;
                    ptr_nxt_s   = lowest_f(bus.msg_mask);
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_r == gap_r) begin
                    state_nxt_s    = FIRE;
                    send_msg_nxt_s = MSG_ONE << ptr_r;
                end else begin
                    gap_cnt_nxt_s  = gap_cnt_r + CNT_ONE;
                end
            end
            FIRE: begin
                state_nxt_s   = WAIT_DONE;
                lat_cnt_nxt_s = CNT_ONE;
            end
            WAIT_DONE: begin
                // A completion in the same cycle as the timeout compare wins over the timeout.
                if (bus.rx_done || (lat_cnt_r == TIMEOUT)) begin
                    done_s            = 1'b1;
                    lat_valid_nxt_s   = 1'b1;
                    lat_value_nxt_s   = bus.rx_done ? lat_cnt_r : TIMEOUT;
                    lat_timeout_nxt_s = ~bus.rx_done;
                    lat_msg_nxt_s     = ptr_r;
                    ptr_nxt_s         = adv_s[3:0];
                    pass_done_nxt_s   = adv_s[4];
                    state_nxt_s       = (adv_s[4] && !bus.continuous) ? IDLE : GAP;
                end else if (lat_cnt_r != CNT_MAX) begin
                    lat_cnt_nxt_s = lat_cnt_r + CNT_ONE;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (launch_s || done_s) begin
            gap_cnt_nxt_s = CNT_ZERO;
        end else begin
            gap_cnt_nxt_s = gap_cnt_nxt_s;
        end
        busy_nxt_s = (state_nxt_s != IDLE);
    end

`ifdef INTERLAKEN_LAT_STATS_EN
    // Statistics follow each completion and restart with every launch.
    always_comb begin
        lat_min_nxt_s      = lat_min_r;
        lat_max_nxt_s      = lat_max_r;
        lat_cnt_stat_nxt_s = lat_cnt_stat_r;
        lost_cnt_nxt_s     = lost_cnt_r;
        if (launch_s) begin
            lat_min_nxt_s      = CNT_MAX;
            lat_max_nxt_s      = CNT_ZERO;
            lat_cnt_stat_nxt_s = 32'd0;
            lost_cnt_nxt_s     = 16'd0;
        end else if (done_s && bus.rx_done) begin
            lat_min_nxt_s      = (lat_cnt_r < lat_min_r) ? lat_cnt_r : lat_min_r;
            lat_max_nxt_s      = (lat_cnt_r > lat_max_r) ? lat_cnt_r : lat_max_r;
            lat_cnt_stat_nxt_s = lat_cnt_stat_r + 32'd1;
        end else if (done_s) begin
            lost_cnt_nxt_s     = lost_cnt_r + 16'd1;
        end else begin
            lost_cnt_nxt_s     = lost_cnt_r;
        end
    end

    // Statistics registers.
    always_ff @(posedge init_clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            lat_min_r      <= CNT_MAX;
            lat_max_r      <= CNT_ZERO;
            lat_cnt_stat_r <= 32'd0;
            lost_cnt_r     <= 16'd0;
        end else begin
            lat_min_r      <= lat_min_nxt_s;
            lat_max_r      <= lat_max_nxt_s;
            lat_cnt_stat_r <= lat_cnt_stat_nxt_s;
            lost_cnt_r     <= lost_cnt_nxt_s;
        end
    end

    assign bus.lat_min  = lat_min_r;
    assign bus.lat_max  = lat_max_r;
    assign bus.lat_cnt  = lat_cnt_stat_r;
    assign bus.lost_cnt = lost_cnt_r;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge init_clk or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            state_r       <= IDLE;
            start_prev_r  <= 1'b0;
            mask_r        <= MSG_ZERO;
            gap_r         <= CNT_ZERO;
            ptr_r         <= 4'd0;
            gap_cnt_r     <= CNT_ZERO;
            lat_cnt_r     <= CNT_ZERO;
            send_msg_r    <= MSG_ZERO;
            busy_r        <= 1'b0;
            lat_valid_r   <= 1'b0;
            lat_value_r   <= CNT_ZERO;
            lat_msg_r     <= 4'd0;
            lat_timeout_r <= 1'b0;
            pass_done_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            start_prev_r  <= bus.start;
            mask_r        <= mask_nxt_s;
            gap_r         <= gap_nxt_s;
            ptr_r         <= ptr_nxt_s;
            gap_cnt_r     <= gap_cnt_nxt_s;
            lat_cnt_r     <= lat_cnt_nxt_s;
            send_msg_r    <= send_msg_nxt_s;
            busy_r        <= busy_nxt_s;
            lat_valid_r   <= lat_valid_nxt_s;
            lat_value_r   <= lat_value_nxt_s;
            lat_msg_r     <= lat_msg_nxt_s;
            lat_timeout_r <= lat_timeout_nxt_s;
            pass_done_r   <= pass_done_nxt_s;
        end
    end

    assign bus.send_msg    = send_msg_r;
    assign bus.busy        = busy_r;
    assign bus.lat_valid   = lat_valid_r;
    assign bus.lat_value   = lat_value_r;
    assign bus.lat_msg     = lat_msg_r;
    assign bus.lat_timeout = lat_timeout_r;
    assign bus.pass_done   = pass_done_r;
endmodule

// File: tb/tb_interlaken_msg_trigger_seq.sv
// Randomized and directed bench for interlaken_msg_trigger_seq, checked every cycle against a
// timeline model (strobe times and latencies computed from gap, delays and the enabled mask).
module tb_interlaken_msg_trigger_seq;
    localparam int          NUM_MSG = 9;
    localparam int          CNT_W   = 16;
    localparam logic [15:0] TO      = 16'd100;

    logic init_clk = 1'b0;
    logic clk_reset_n = 1'b0;

    interlaken_msg_trigger_seq_if #(.NUM_MSG(NUM_MSG), .CNT_W(CNT_W)) bus ();

    interlaken_msg_trigger_seq #(.NUM_MSG(NUM_MSG), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .init_clk    (init_clk),
        .clk_reset_n (clk_reset_n),
        .bus         (bus)
    );

    always #5 init_clk = ~init_clk;

    int n_vec = 0, n_err = 0, cyc = 0, rx_due = -1, rsp_dly = 20, pass_cnt = 0;
    bit rsp_en = 1'b0, rnd_dly = 1'b0, stray_en = 1'b0, force_rx = 1'b0;
    int dly_q[$];
    // model state: busy flag, latched config, pointer, scheduled and actual strobe cycles
    bit m_busy, m_wait, m_prev_start;
    logic [8:0] m_mask;
    int m_gap, m_ptr, m_fire_at, m_fire_cyc;
    logic [8:0] e_send;
    bit e_busy, e_valid, e_pass, e_to;
    int e_val, e_msg;
    int log_msg[$], log_val[$], log_to[$], strobe_cyc[$], strobe_idx[$], valid_cyc[$];
`ifdef INTERLAKEN_LAT_STATS_EN
    logic [15:0] e_min, e_max;
    int e_cnt, e_lost;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int first_set(input logic [8:0] m, input int after);
        for (int i = 0; i < NUM_MSG; i++) if (m[i] && i > after) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_prev_start = 0; rx_due = -1;
        e_send = '0; e_busy = 0; e_valid = 0; e_pass = 0;
`ifdef INTERLAKEN_LAT_STATS_EN
        e_min = 16'hFFFF; e_max = 16'd0; e_cnt = 0; e_lost = 0;
`endif
    endtask

    // Predict the outputs of cycle cyc+1 from the inputs presented during cycle cyc.
    task automatic model_step();
        int n, nxt;
        bit wrap;
        n = cyc + 1;
        e_send = '0; e_valid = 0; e_pass = 0;
        if (!m_busy) begin
            if (bus.start && !m_prev_start && bus.msg_mask != 9'd0) begin
                m_busy = 1; m_wait = 0; m_mask = bus.msg_mask; m_gap = int'(bus.gap_cycles);
                m_ptr = first_set(m_mask, -1); m_fire_at = n + m_gap + 1;
`ifdef INTERLAKEN_LAT_STATS_EN
                e_min = 16'hFFFF; e_max = 16'd0; e_cnt = 0; e_lost = 0;
`endif
            end
        end else begin
            if (m_wait && cyc > m_fire_cyc && (bus.rx_done || (cyc - m_fire_cyc) == int'(TO))) begin
                e_valid = 1; e_to = !bus.rx_done; e_msg = m_ptr;
                e_val = bus.rx_done ? (cyc - m_fire_cyc) : int'(TO);
                log_msg.push_back(e_msg); log_val.push_back(e_val); log_to.push_back(int'(e_to));
`ifdef INTERLAKEN_LAT_STATS_EN
                if (e_to) e_lost++;
                else begin
                    e_cnt++;
                    if (e_val < int'(e_min)) e_min = 16'(e_val);
                    if (e_val > int'(e_max)) e_max = 16'(e_val);
                end
`endif
                nxt = first_set(m_mask, m_ptr);
                wrap = (nxt < 0);
                if (wrap) nxt = first_set(m_mask, -1);
                e_pass = wrap; m_ptr = nxt; m_wait = 0;
                if (wrap && !bus.continuous) m_busy = 0;
                else m_fire_at = n + m_gap + 1;
            end
            if (m_busy && !m_wait && n == m_fire_at) begin
                e_send = 9'd1 << m_ptr; m_fire_cyc = n; m_wait = 1;
            end
        end
        e_busy = m_busy;
        m_prev_start = bus.start;
    endtask

    task automatic check_outputs();
        int d;
        chk("send_msg", bus.send_msg, e_send);
        chk("busy", bus.busy, e_busy);
        chk("lat_valid", bus.lat_valid, e_valid);
        chk("pass_done", bus.pass_done, e_pass);
        if (e_valid) begin
            chk("lat_value", bus.lat_value, e_val);
            chk("lat_msg", bus.lat_msg, e_msg);
            chk("lat_timeout", bus.lat_timeout, e_to);
        end
`ifdef INTERLAKEN_LAT_STATS_EN
        chk("lat_min", bus.lat_min, e_min);
        chk("lat_max", bus.lat_max, e_max);
        chk("lat_cnt", bus.lat_cnt, e_cnt);
        chk("lost_cnt", bus.lost_cnt, e_lost);
`endif
        if (bus.send_msg != 9'd0) begin
            strobe_cyc.push_back(cyc);
            for (int i = 0; i < NUM_MSG; i++) if (bus.send_msg[i]) strobe_idx.push_back(i);
            if (rsp_en) begin
                d = (dly_q.size() > 0) ? dly_q.pop_front() :
                    (rnd_dly ? (($urandom_range(0, 9) == 0) ? 120 : int'($urandom_range(1, 40))) : rsp_dly);
                rx_due = (d == 0) ? -1 : cyc + d;
            end
        end
        if (bus.lat_valid) valid_cyc.push_back(cyc);
        if (bus.pass_done) pass_cnt++;
    endtask

    task automatic tick();
        bus.rx_done = (cyc == rx_due) || force_rx || (stray_en && $urandom_range(0, 19) == 0);
        model_step();
        @(posedge init_clk);
        @(negedge init_clk);
        cyc++;
        check_outputs();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
    endtask

    task automatic run_until_idle(input int max, input string name);
        int k = 0;
        while ((m_busy || bus.busy) && k < max) begin tick(); k++; end
        chk(name, k < max, 1);
    endtask

    task automatic apply_reset(input int cycles);
        clk_reset_n = 1'b0;
        model_reset();
        #1 check_outputs();
        for (int i = 0; i < cycles; i++) begin
            bus.start = i[0];
            @(posedge init_clk);
            @(negedge init_clk);
            cyc++;
            check_outputs();
        end
        bus.start = 1'b0; bus.rx_done = 1'b0;
        clk_reset_n = 1'b1;
    endtask

    task automatic clear_logs();
        log_msg.delete(); log_val.delete(); log_to.delete();
        strobe_cyc.delete(); strobe_idx.delete(); valid_cyc.delete(); pass_cnt = 0;
    endtask

    initial begin
        int exp_sp[3];
        int exp_ct[6];
        int k;
        bus.start = 0; bus.continuous = 0; bus.msg_mask = '0; bus.gap_cycles = '0; bus.rx_done = 0;
        @(negedge init_clk);
        apply_reset(10);
        repeat (3) tick();
        chk("idle_after_reset", bus.busy, 0);

        // single pass 0,4,8 with fixed 20-cycle responses
        clear_logs(); rsp_en = 1; rsp_dly = 20;
        bus.msg_mask = 9'h111; bus.gap_cycles = 16'd3; bus.continuous = 0;
        pulse_start();
        run_until_idle(2000, "sp_idle");
        exp_sp = '{0, 4, 8};
        chk("sp_count", log_val.size(), 3);
        chk("sp_pass", pass_cnt, 1);
        if (log_val.size() == 3 && strobe_idx.size() == 3 && valid_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("sp_val", log_val[i], 20);
                chk("sp_msg", log_msg[i], exp_sp[i]);
                chk("sp_strobe", strobe_idx[i], exp_sp[i]);
            end
            chk("sp_gap1", strobe_cyc[1] - valid_cyc[0], 4);
            chk("sp_gap2", strobe_cyc[2] - valid_cyc[1], 4);
        end

        // timeout on message 1
        clear_logs(); rsp_en = 0;
        bus.msg_mask = 9'h002; bus.gap_cycles = 16'd2;
        pulse_start();
        run_until_idle(400, "to_idle");
        chk("to_count", log_val.size(), 1);
        if (log_val.size() == 1) begin
            chk("to_flag", log_to[0], 1); chk("to_val", log_val[0], 100); chk("to_msg", log_msg[0], 1);
        end

        // continuous wrap over 7,8 for three passes
        clear_logs(); rsp_en = 1; rsp_dly = 5;
        bus.msg_mask = 9'h180; bus.gap_cycles = 16'd0; bus.continuous = 1;
        pulse_start();
        k = 0;
        while (pass_cnt < 2 && k < 500) begin tick(); k++; end
        chk("ct_bound", k < 500, 1);
        bus.continuous = 0;
        run_until_idle(500, "ct_idle");
        exp_ct = '{7, 8, 7, 8, 7, 8};
        chk("ct_strobes", strobe_idx.size(), 6);
        chk("ct_pass", pass_cnt, 3);
        if (strobe_idx.size() == 6) for (int i = 0; i < 6; i++) chk("ct_order", strobe_idx[i], exp_ct[i]);

        // rx_done in GAP and start re-pulses while busy are ignored
        clear_logs(); rsp_dly = 15;
        bus.msg_mask = 9'h003; bus.gap_cycles = 16'd10;
        pulse_start();
        force_rx = 1; tick(); tick(); force_rx = 0;
        pulse_start(); bus.msg_mask = 9'h1FF; bus.gap_cycles = 16'd0;
        repeat (20) tick();
        pulse_start();
        run_until_idle(500, "edge_idle");
        chk("edge_count", log_val.size(), 2);

        // rx_done coincident with the timeout compare
        clear_logs(); rsp_dly = 100;
        bus.msg_mask = 9'h004; bus.gap_cycles = 16'd0;
        pulse_start();
        run_until_idle(400, "co_idle");
        chk("co_count", log_val.size(), 1);
        if (log_val.size() == 1) begin
            chk("co_flag", log_to[0], 0); chk("co_val", log_val[0], 100); chk("co_msg", log_msg[0], 2);
        end

        // empty mask never launches
        clear_logs(); bus.msg_mask = 9'h000;
        pulse_start(); repeat (5) tick();
        chk("m0_busy", bus.busy, 0);
        chk("m0_strobes", strobe_idx.size(), 0);

`ifdef INTERLAKEN_LAT_STATS_EN
        clear_logs(); dly_q = '{12, 30, 7, 0};
        bus.msg_mask = 9'h00F; bus.gap_cycles = 16'd1;
        pulse_start();
        run_until_idle(800, "st_idle");
        chk("st_min", bus.lat_min, 7); chk("st_max", bus.lat_max, 30);
        chk("st_cnt", bus.lat_cnt, 3); chk("st_lost", bus.lost_cnt, 1);
`endif

        // asynchronous reset in the middle of a continuous run
        bus.msg_mask = 9'h1FF; bus.gap_cycles = 16'd1; bus.continuous = 1; rsp_dly = 10;
        pulse_start();
        repeat (30) tick();
        apply_reset(3);
        repeat (3) tick();
        chk("rst_mid_busy", bus.busy, 0);

        // randomized runs with stray rx_done, start toggles and config changes while busy
        rnd_dly = 1; stray_en = 1;
        for (int it = 0; it < 20; it++) begin
            bus.msg_mask = 9'($urandom_range(0, 511));
            bus.gap_cycles = 16'($urandom_range(0, 4));
            bus.continuous = ($urandom_range(0, 2) == 0);
            pulse_start();
            for (int c = 0; c < 800 && (m_busy || bus.busy); c++) begin
                bus.start = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 31) == 0) bus.msg_mask = 9'($urandom_range(0, 511));
                if ($urandom_range(0, 199) == 0) bus.continuous = 0;
                tick();
            end
            bus.start = 0; bus.continuous = 0;
            run_until_idle(2500, "rnd_idle");
        end
        stray_en = 0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
